soc_axi_arb: RTL

- Two-requester AXI4 arbiter that shares one downstream AXI4 master port between inport0 and inport1.
- Sits in front of soc_axi_retime, for example CPU plus DMA sharing the memory path.
- Read and write directions are arbitrated independently.
- Each direction has at most one transaction in flight, so the grant is held from address through final response.
- Response routing is by grant register; AXI IDs pass through unmodified.

---
 rtl/soc_axi_arb_pkg.sv | 30 +++
 rtl/soc_axi_arb_pick.sv | 22 ++
 rtl/soc_axi_arb.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/soc_axi_arb_pkg.sv
// soc_axi_arb_pkg: shared definitions for the two-requester AXI4 arbiter.
//   - Packed channel widths used to mux whole AXI channels as one vector.
//   - Write and read FSM state encodings.
package soc_axi_arb_pkg;

  // {addr, id, len, burst}
  localparam int AW_CH_W = 46;
  // {data, strb, last}
  localparam int W_CH_W  = 37;
  // {resp, id}
  localparam int B_CH_W  = 6;
  // {addr, id, len, burst}
  localparam int AR_CH_W = 46;
  // {data, resp, id, last}
  localparam int R_CH_W  = 39;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

endpackage

// File: rtl/soc_axi_arb_pick.sv
// soc_axi_arb_pick: 2-way combinational request picker.
//   req[1:0] : request from port1/port0
//   last     : port served most recently (0 = port0, 1 = port1)
//   rr_en    : 1 = round-robin on contention, 0 = port0 always wins
//   grant    : selected port (only meaningful when req != 0)
module soc_axi_arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    case (req)
      2'b10:   grant = 1'b1;
      2'b11:   grant = rr_en ? ~last : 1'b0;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/soc_axi_arb.sv
// soc_axi_arb: shares one downstream AXI4 master port between two requesters.
// Read and write directions are arbitrated independently; each direction
// holds its grant from address phase through the final response, so at most
// one transaction per direction is in flight. Responses are steered by the
// grant register and IDs pass through untouched.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   inport0_* / 1_*   : AXI4 slave-side ports facing the two requesters
//   outport_*         : shared AXI4 master-side port
//   ARB_ROUND_ROBIN   : 1 = round-robin on contention, 0 = port0 priority
module soc_axi_arb
  import soc_axi_arb_pkg::*;
#(
  parameter int unsigned ARB_ROUND_ROBIN = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inport0_awvalid_i,
  input  logic [31:0] inport0_awaddr_i,
  input  logic [3:0]  inport0_awid_i,
  input  logic [7:0]  inport0_awlen_i,
  input  logic [1:0]  inport0_awburst_i,
  output logic        inport0_awready_o,
  input  logic        inport0_wvalid_i,
  input  logic [31:0] inport0_wdata_i,
  input  logic [3:0]  inport0_wstrb_i,
  input  logic        inport0_wlast_i,
  output logic        inport0_wready_o,
  input  logic        inport0_bready_i,
  output logic        inport0_bvalid_o,
  output logic [1:0]  inport0_bresp_o,
  output logic [3:0]  inport0_bid_o,
  input  logic        inport0_arvalid_i,
  input  logic [31:0] inport0_araddr_i,
  input  logic [3:0]  inport0_arid_i,
  input  logic [7:0]  inport0_arlen_i,
  input  logic [1:0]  inport0_arburst_i,
  output logic        inport0_arready_o,
  input  logic        inport0_rready_i,
  output logic        inport0_rvalid_o,
  output logic [31:0] inport0_rdata_o,
  output logic [1:0]  inport0_rresp_o,
  output logic [3:0]  inport0_rid_o,
  output logic        inport0_rlast_o,
  input  logic        inport1_awvalid_i,
  input  logic [31:0] inport1_awaddr_i,
  input  logic [3:0]  inport1_awid_i,
  input  logic [7:0]  inport1_awlen_i,
  input  logic [1:0]  inport1_awburst_i,
  output logic        inport1_awready_o,
  input  logic        inport1_wvalid_i,
  input  logic [31:0] inport1_wdata_i,
  input  logic [3:0]  inport1_wstrb_i,
  input  logic        inport1_wlast_i,
  output logic        inport1_wready_o,
  input  logic        inport1_bready_i,
  output logic        inport1_bvalid_o,
  output logic [1:0]  inport1_bresp_o,
  output logic [3:0]  inport1_bid_o,
  input  logic        inport1_arvalid_i,
  input  logic [31:0] inport1_araddr_i,
  input  logic [3:0]  inport1_arid_i,
  input  logic [7:0]  inport1_arlen_i,
  input  logic [1:0]  inport1_arburst_i,
  output logic        inport1_arready_o,
  input  logic        inport1_rready_i,
  output logic        inport1_rvalid_o,
  output logic [31:0] inport1_rdata_o,
  output logic [1:0]  inport1_rresp_o,
  output logic [3:0]  inport1_rid_o,
  output logic        inport1_rlast_o,
  output logic        outport_awvalid_o,
  output logic [31:0] outport_awaddr_o,
  output logic [3:0]  outport_awid_o,
  output logic [7:0]  outport_awlen_o,
  output logic [1:0]  outport_awburst_o,
  input  logic        outport_awready_i,
  output logic        outport_wvalid_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  output logic        outport_wlast_o,
  input  logic        outport_wready_i,
  input  logic        outport_bvalid_i,
  input  logic [1:0]  outport_bresp_i,
  input  logic [3:0]  outport_bid_i,
  output logic        outport_bready_o,
  output logic        outport_arvalid_o,
  output logic [31:0] outport_araddr_o,
  output logic [3:0]  outport_arid_o,
  output logic [7:0]  outport_arlen_o,
  output logic [1:0]  outport_arburst_o,
  input  logic        outport_arready_i,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i,
  output logic        outport_rready_o
);

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;
  logic      wr_grant_q, wr_grant_d, wr_last_q, wr_last_d;
  logic      rd_grant_q, rd_grant_d, rd_last_q, rd_last_d;
  logic      wr_pick, rd_pick;

  soc_axi_arb_pick u_wr_pick (
    .req   ({inport1_awvalid_i, inport0_awvalid_i}),
    .last  (wr_last_q),
    .rr_en (ARB_ROUND_ROBIN != 0),
    .grant (wr_pick)
  );

  soc_axi_arb_pick u_rd_pick (
    .req   ({inport1_arvalid_i, inport0_arvalid_i}),
    .last  (rd_last_q),
    .rr_en (ARB_ROUND_ROBIN != 0),
    .grant (rd_pick)
  );

  // Payload muxing by grant register; payload is don't-care while valid is low.
  logic [AW_CH_W-1:0] aw_ch0, aw_ch1;
  logic [W_CH_W-1:0]  w_ch0, w_ch1;
  logic [AR_CH_W-1:0] ar_ch0, ar_ch1;
  logic [B_CH_W-1:0]  b_ch;
  logic [R_CH_W-1:0]  r_ch;

  assign aw_ch0 = {inport0_awaddr_i, inport0_awid_i, inport0_awlen_i, inport0_awburst_i};
  assign aw_ch1 = {inport1_awaddr_i, inport1_awid_i, inport1_awlen_i, inport1_awburst_i};
  assign w_ch0  = {inport0_wdata_i, inport0_wstrb_i, inport0_wlast_i};
  assign w_ch1  = {inport1_wdata_i, inport1_wstrb_i, inport1_wlast_i};
  assign ar_ch0 = {inport0_araddr_i, inport0_arid_i, inport0_arlen_i, inport0_arburst_i};
  assign ar_ch1 = {inport1_araddr_i, inport1_arid_i, inport1_arlen_i, inport1_arburst_i};
  assign b_ch   = {outport_bresp_i, outport_bid_i};
  assign r_ch   = {outport_rdata_i, outport_rresp_i, outport_rid_i, outport_rlast_i};

  assign {outport_awaddr_o, outport_awid_o, outport_awlen_o, outport_awburst_o} =
    wr_grant_q ? aw_ch1 : aw_ch0;
  assign {outport_wdata_o, outport_wstrb_o, outport_wlast_o} = wr_grant_q ? w_ch1 : w_ch0;
  assign {outport_araddr_o, outport_arid_o, outport_arlen_o, outport_arburst_o} =
    rd_grant_q ? ar_ch1 : ar_ch0;
  assign {inport0_bresp_o, inport0_bid_o} = b_ch;
  assign {inport1_bresp_o, inport1_bid_o} = b_ch;
  assign {inport0_rdata_o, inport0_rresp_o, inport0_rid_o, inport0_rlast_o} = r_ch;
  assign {inport1_rdata_o, inport1_rresp_o, inport1_rid_o, inport1_rlast_o} = r_ch;

  logic wr_in_addr, wr_in_data, wr_in_resp, rd_in_addr, rd_in_data;
  assign wr_in_addr = (wr_state_q == W_ADDR);
  assign wr_in_data = (wr_state_q == W_DATA);
  assign wr_in_resp = (wr_state_q == W_RESP);
  assign rd_in_addr = (rd_state_q == R_ADDR);
  assign rd_in_data = (rd_state_q == R_DATA);

  // Handshake signals are gated by FSM state and grant.
  assign outport_awvalid_o = wr_in_addr & (wr_grant_q ? inport1_awvalid_i : inport0_awvalid_i);
  assign inport0_awready_o = wr_in_addr & ~wr_grant_q & outport_awready_i;
  assign inport1_awready_o = wr_in_addr &  wr_grant_q & outport_awready_i;
  assign outport_wvalid_o  = wr_in_data & (wr_grant_q ? inport1_wvalid_i : inport0_wvalid_i);
  assign inport0_wready_o  = wr_in_data & ~wr_grant_q & outport_wready_i;
  assign inport1_wready_o  = wr_in_data &  wr_grant_q & outport_wready_i;
  assign outport_bready_o  = wr_in_resp & (wr_grant_q ? inport1_bready_i : inport0_bready_i);
  assign inport0_bvalid_o  = wr_in_resp & ~wr_grant_q & outport_bvalid_i;
  assign inport1_bvalid_o  = wr_in_resp &  wr_grant_q & outport_bvalid_i;
  assign outport_arvalid_o = rd_in_addr & (rd_grant_q ? inport1_arvalid_i : inport0_arvalid_i);
  assign inport0_arready_o = rd_in_addr & ~rd_grant_q & outport_arready_i;
  assign inport1_arready_o = rd_in_addr &  rd_grant_q & outport_arready_i;
  assign outport_rready_o  = rd_in_data & (rd_grant_q ? inport1_rready_i : inport0_rready_i);
  assign inport0_rvalid_o  = rd_in_data & ~rd_grant_q & outport_rvalid_i;
  assign inport1_rvalid_o  = rd_in_data &  rd_grant_q & outport_rvalid_i;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_grant_d = wr_grant_q;
    wr_last_d  = wr_last_q;
    case (wr_state_q)
      W_IDLE: if (inport0_awvalid_i | inport1_awvalid_i) begin
        wr_grant_d = wr_pick;
        wr_state_d = W_ADDR;
      end
      W_ADDR: if (outport_awvalid_o & outport_awready_i) wr_state_d = W_DATA;
      W_DATA: if (outport_wvalid_o & outport_wready_i & outport_wlast_o) wr_state_d = W_RESP;
      W_RESP: if (outport_bvalid_i & outport_bready_o) begin
        wr_last_d  = wr_grant_q;
        wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_grant_d = rd_grant_q;
    rd_last_d  = rd_last_q;
    case (rd_state_q)
      R_IDLE: if (inport0_arvalid_i | inport1_arvalid_i) begin
        rd_grant_d = rd_pick;
        rd_state_d = R_ADDR;
      end
      R_ADDR: if (outport_arvalid_o & outport_arready_i) rd_state_d = R_DATA;
      R_DATA: if (outport_rvalid_i & outport_rready_o & outport_rlast_i) begin
        rd_last_d  = rd_grant_q;
        rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // last_q starts at 1 so port0 wins the first contention after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= W_IDLE;
      wr_grant_q <= 1'b0;
      wr_last_q  <= 1'b1;
      rd_state_q <= R_IDLE;
      rd_grant_q <= 1'b0;
      rd_last_q  <= 1'b1;
    end else begin
      wr_state_q <= wr_state_d;
      wr_grant_q <= wr_grant_d;
      wr_last_q  <= wr_last_d;
      rd_state_q <= rd_state_d;
      rd_grant_q <= rd_grant_d;
      rd_last_q  <= rd_last_d;
    end
  end

endmodule
